// File: rtl/result_uart_tx.sv
// Purpose : serialises the 48-bit CPU result word as a 7-byte UART frame
//           (header byte, then q[7:0] .. q[47:40]) whenever q changes or a send is forced.
// Latency : the start bit appears on the edge after the trigger is sampled; a frame is 70*CLK_DIV cycles.
// Backpr. : none; changes of q and force pulses while busy are dropped, and the trigger is re-checked once back in IDLE.
//
// Ports:
//   i_clk    system clock, rising edge
//   i_rst_n  asynchronous active-low reset (aborts any frame, txd high at once)
//   i_en     permits new frames to start (a frame in flight always completes)
//   i_force  one-cycle request to resend q even if unchanged
//   i_q      48-bit CPU result word
//   o_txd    UART serial output, 8N1, LSB first, idle high
//   o_busy   high from the first start bit to the end of the last stop bit
//   o_done   one-cycle pulse when a frame completes
module result_uart_tx #(
  parameter int         CLK_DIV = 434,
  parameter logic [7:0] HDR     = 8'hA5
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_en,
  input  logic        i_force,
  input  logic [47:0] i_q,
  output logic        o_txd,
  output logic        o_busy,
  output logic        o_done
);

  localparam int            TW   = $clog2(CLK_DIV);
  localparam logic [TW-1:0] TMAX = TW'(CLK_DIV - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } state_t;

  state_t        r_state,     w_state;
  logic [TW-1:0] r_timer,     w_timer;
  logic [2:0]    r_bit_idx,   w_bit_idx;
  logic [2:0]    r_byte_idx,  w_byte_idx;
  logic [47:0]   r_snap,      w_snap;
  logic [47:0]   r_last_sent, w_last_sent;
  logic          r_txd,       w_txd;
  logic          r_busy,      w_busy;
  logic          r_done,      w_done;

  logic [55:0]   w_frame;
  logic [7:0]    w_cur_byte;
  logic          w_bit_end;
  logic          w_trig;

  // Byte 0 of the frame is the header, bytes 1..6 are the snapshot LSB first.
  assign w_frame    = {r_snap, HDR};
  assign w_cur_byte = w_frame[{r_byte_idx, 3'b000} +: 8];
  assign w_bit_end  = (r_timer == TMAX);
  assign w_trig     = i_en & ((i_q != r_last_sent) | i_force);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= S_IDLE;
      r_timer     <= '0;
      r_bit_idx   <= '0;
      r_byte_idx  <= '0;
      r_snap      <= '0;
      r_last_sent <= '0;
      r_txd       <= 1'b1;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_state     <= w_state;
      r_timer     <= w_timer;
      r_bit_idx   <= w_bit_idx;
      r_byte_idx  <= w_byte_idx;
      r_snap      <= w_snap;
      r_last_sent <= w_last_sent;
      r_txd       <= w_txd;
      r_busy      <= w_busy;
      r_done      <= w_done;
    end
  end

  always_comb begin
    w_state     = r_state;
    w_timer     = r_timer;
    w_bit_idx   = r_bit_idx;
    w_byte_idx  = r_byte_idx;
    w_snap      = r_snap;
    w_last_sent = r_last_sent;
    w_txd       = r_txd;
    w_busy      = r_busy;
    w_done      = 1'b0;

    case (r_state)
      S_IDLE: begin
        w_txd   = 1'b1;
        w_timer = '0;
        if (w_trig) begin
          // Capture q once; later changes wait for the post-frame re-check.
          w_state     = S_START;
          w_snap      = i_q;
          w_last_sent = i_q;
          w_byte_idx  = 3'd0;
          w_txd       = 1'b0;
          w_busy      = 1'b1;
        end
      end

      S_START: begin
        if (w_bit_end) begin
          w_timer   = '0;
          w_state   = S_DATA;
          w_bit_idx = 3'd0;
          w_txd     = w_cur_byte[0];
        end else begin
          w_timer = r_timer + TW'(1);
        end
      end

      S_DATA: begin
        if (w_bit_end) begin
          w_timer = '0;
          if (r_bit_idx == 3'd7) begin
            w_state = S_STOP;
            w_txd   = 1'b1;
          end else begin
            w_bit_idx = r_bit_idx + 3'd1;
            w_txd     = w_cur_byte[r_bit_idx + 3'd1];
          end
        end else begin
          w_timer = r_timer + TW'(1);
        end
      end

      S_STOP: begin
        if (w_bit_end) begin
          w_timer = '0;
          if (r_byte_idx < 3'd6) begin
            // Next byte's start bit follows the stop bit directly.
            w_byte_idx = r_byte_idx + 3'd1;
            w_state    = S_START;
            w_txd      = 1'b0;
          end else begin
            w_state = S_IDLE;
            w_busy  = 1'b0;
            w_done  = 1'b1;
          end
        end else begin
          w_timer = r_timer + TW'(1);
        end
      end

      default: begin
        w_state = S_IDLE;
        w_txd   = 1'b1;
        w_busy  = 1'b0;
      end
    endcase
  end

  assign o_txd  = r_txd;
  assign o_busy = r_busy;
  assign o_done = r_done;

endmodule

// File: tb/tb_result_uart_tx.sv
// Directed bench for result_uart_tx with CLK_DIV=4 (one frame = 280 cycles).
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_result_uart_tx;

  localparam int CLK_DIV = 4;
  localparam int FBITS   = 70 * CLK_DIV;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic        en    = 1'b0;
  logic        frc   = 1'b0;
  logic [47:0] q     = '0;
  logic        txd;
  logic        busy;
  logic        done;

  int n_checks = 0;
  int n_fail   = 0;

  // Capture buffers: sample 0 is the first falling edge with txd low.
  logic        cap_txd  [0:FBITS];
  logic        cap_busy [0:FBITS];
  logic        cap_done [0:FBITS];
  bit          rx_found;
  int          rx_wait;
  logic [55:0] rx_frame;
  int          rx_bit_err;
  int          rx_busy_cnt;
  int          rx_done_cnt;

  result_uart_tx #(.CLK_DIV(CLK_DIV), .HDR(8'hA5)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_en    (en),
    .i_force (frc),
    .i_q     (q),
    .o_txd   (txd),
    .o_busy  (busy),
    .o_done  (done)
  );

  always #5 clk = ~clk;

  // Waits up to max_wait falling edges for a start bit, then records one
  // full frame plus the following cycle and decodes it (no checks here).
  task automatic capture(input int max_wait);
    rx_found    = 1'b0;
    rx_wait     = 0;
    rx_frame    = '0;
    rx_bit_err  = 0;
    rx_busy_cnt = 0;
    rx_done_cnt = 0;
    for (int n = 1; n <= max_wait && !rx_found; n++) begin
      @(negedge clk);
      if (txd === 1'b0) begin
        rx_found = 1'b1;
        rx_wait  = n;
      end
    end
    if (!rx_found) return;
    cap_txd[0]  = txd;
    cap_busy[0] = busy;
    cap_done[0] = done;
    for (int s = 1; s <= FBITS; s++) begin
      @(negedge clk);
      cap_txd[s]  = txd;
      cap_busy[s] = busy;
      cap_done[s] = done;
    end
    for (int k = 0; k < 7; k++) begin
      int base;
      base = k * 10 * CLK_DIV;
      if (cap_txd[base] !== 1'b0) rx_bit_err++;
      if (cap_txd[base + 9 * CLK_DIV] !== 1'b1) rx_bit_err++;
      for (int b = 0; b < 10; b++)
        for (int j = 1; j < CLK_DIV; j++)
          if (cap_txd[base + b * CLK_DIV + j] !== cap_txd[base + b * CLK_DIV]) rx_bit_err++;
      for (int i = 0; i < 8; i++)
        rx_frame[k * 8 + i] = cap_txd[base + (1 + i) * CLK_DIV];
    end
    if (cap_txd[FBITS] !== 1'b1) rx_bit_err++;
    for (int s = 0; s <= FBITS; s++) begin
      if (cap_busy[s] === 1'b1) rx_busy_cnt++;
      if (cap_done[s] === 1'b1) rx_done_cnt++;
    end
  endtask

  task automatic test_reset();
    int bad;
    rst_n = 1'b0; en = 1'b0; frc = 1'b0; q = '0;
    repeat (3) @(negedge clk);
    n_checks++;
    if (txd !== 1'b1) begin n_fail++; $display("FAIL reset_txd: got %b expected 1", txd); end
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
    n_checks++;
    if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", done); end
    rst_n = 1'b1; en = 1'b1;
    bad = 0;
    repeat (500) begin
      @(negedge clk);
      if (txd !== 1'b1 || busy !== 1'b0 || done !== 1'b0) bad++;
    end
    n_checks++;
    if (bad != 0) begin n_fail++; $display("FAIL idle_quiet: got %0d active cycles expected 0", bad); end
  endtask

  task automatic test_basic_frame();
    @(negedge clk);
    q = 48'h0123456789AB;
    capture(4);
    n_checks++;
    if (!rx_found || rx_wait != 1) begin
      n_fail++; $display("FAIL basic_start: found=%0d wait=%0d expected found=1 wait=1", rx_found, rx_wait);
    end
    n_checks++;
    if (rx_frame !== 56'h0123456789ABA5) begin
      n_fail++; $display("FAIL basic_bytes: got %h expected 0123456789aba5", rx_frame);
    end
    n_checks++;
    if (rx_bit_err != 0) begin n_fail++; $display("FAIL basic_bit_width: got %0d errors expected 0", rx_bit_err); end
    n_checks++;
    if (rx_busy_cnt != FBITS) begin n_fail++; $display("FAIL basic_busy_len: got %0d expected %0d", rx_busy_cnt, FBITS); end
    n_checks++;
    if (rx_done_cnt != 1 || cap_done[FBITS] !== 1'b1) begin
      n_fail++; $display("FAIL basic_done: got count=%0d last=%b expected count=1 last=1", rx_done_cnt, cap_done[FBITS]);
    end
    @(negedge clk);
    n_checks++;
    if (done !== 1'b0 || busy !== 1'b0 || txd !== 1'b1) begin
      n_fail++; $display("FAIL basic_after: got done=%b busy=%b txd=%b expected 0 0 1", done, busy, txd);
    end
  endtask

  task automatic test_mid_frame_change();
    @(negedge clk);
    q = 48'h1;
    fork
      capture(4);
      begin
        repeat (60) @(negedge clk);
        q = 48'h2;
        repeat (60) @(negedge clk);
        q = 48'h3;
      end
    join
    n_checks++;
    if (!rx_found || rx_frame !== 56'h000000000001A5) begin
      n_fail++; $display("FAIL mid_first: found=%0d got %h expected 000000000001a5", rx_found, rx_frame);
    end
    capture(2);
    n_checks++;
    if (!rx_found || rx_wait != 1) begin
      n_fail++; $display("FAIL mid_gap: found=%0d wait=%0d expected found=1 wait=1", rx_found, rx_wait);
    end
    n_checks++;
    if (rx_frame !== 56'h000000000003A5) begin
      n_fail++; $display("FAIL mid_followup: got %h expected 000000000003a5", rx_frame);
    end
    capture(300);
    n_checks++;
    if (rx_found) begin n_fail++; $display("FAIL mid_no_extra: got frame %h expected none", rx_frame); end
  endtask

  task automatic test_force();
    @(negedge clk);
    frc = 1'b1;
    fork
      capture(4);
      begin
        @(negedge clk);
        frc = 1'b0;
        repeat (100) @(negedge clk);
        frc = 1'b1;
        @(negedge clk);
        frc = 1'b0;
      end
    join
    n_checks++;
    if (!rx_found || rx_wait != 1) begin
      n_fail++; $display("FAIL force_start: found=%0d wait=%0d expected found=1 wait=1", rx_found, rx_wait);
    end
    n_checks++;
    if (rx_frame !== 56'h000000000003A5) begin
      n_fail++; $display("FAIL force_bytes: got %h expected 000000000003a5", rx_frame);
    end
    capture(300);
    n_checks++;
    if (rx_found) begin n_fail++; $display("FAIL force_busy_ignored: got frame %h expected none", rx_frame); end
  endtask

  task automatic test_enable_gating();
    int act;
    @(negedge clk);
    en = 1'b0;
    q  = 48'hFFFF;
    act = 0;
    repeat (300) begin
      @(negedge clk);
      if (txd !== 1'b1 || busy !== 1'b0) act++;
    end
    n_checks++;
    if (act != 0) begin n_fail++; $display("FAIL en_gated: got %0d active cycles expected 0", act); end
    en = 1'b1;
    fork
      capture(4);
      begin
        repeat (100) @(negedge clk);
        en = 1'b0;
        q  = 48'h7;
      end
    join
    n_checks++;
    if (!rx_found || rx_wait != 1) begin
      n_fail++; $display("FAIL en_start: found=%0d wait=%0d expected found=1 wait=1", rx_found, rx_wait);
    end
    n_checks++;
    if (rx_frame !== 56'h00000000FFFFA5) begin
      n_fail++; $display("FAIL en_bytes: got %h expected 00000000ffffa5", rx_frame);
    end
    n_checks++;
    if (rx_busy_cnt != FBITS || rx_done_cnt != 1 || rx_bit_err != 0) begin
      n_fail++; $display("FAIL en_drop_completes: got busy=%0d done=%0d err=%0d expected %0d 1 0",
                         rx_busy_cnt, rx_done_cnt, rx_bit_err, FBITS);
    end
    capture(300);
    n_checks++;
    if (rx_found) begin n_fail++; $display("FAIL en_low_no_start: got frame %h expected none", rx_frame); end
  endtask

  task automatic test_async_reset();
    en = 1'b1;
    repeat (131) @(negedge clk);
    n_checks++;
    if (busy !== 1'b1) begin n_fail++; $display("FAIL arst_pre_busy: got %b expected 1", busy); end
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if (txd !== 1'b1) begin n_fail++; $display("FAIL arst_txd: got %b expected 1", txd); end
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      n_fail++; $display("FAIL arst_busy_done: got busy=%b done=%b expected 0 0", busy, done);
    end
    @(negedge clk);
    q     = 48'h5;
    rst_n = 1'b1;
    capture(4);
    n_checks++;
    if (!rx_found || rx_wait != 1) begin
      n_fail++; $display("FAIL arst_restart: found=%0d wait=%0d expected found=1 wait=1", rx_found, rx_wait);
    end
    n_checks++;
    if (rx_frame !== 56'h000000000005A5) begin
      n_fail++; $display("FAIL arst_bytes: got %h expected 000000000005a5", rx_frame);
    end
    n_checks++;
    if (rx_busy_cnt != FBITS || rx_bit_err != 0) begin
      n_fail++; $display("FAIL arst_frame_len: got busy=%0d err=%0d expected %0d 0", rx_busy_cnt, rx_bit_err, FBITS);
    end
  endtask

  initial begin
    test_reset();
    test_basic_frame();
    test_mid_frame_change();
    test_force();
    test_enable_gating();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
